// File: rtl/alu_operand_sequencer.sv
// ALU operand sequencer.
// Collects operand A, operand B and then the opcode from one shared 3-bit
// switch bus, one value per load-button press. It drives the ALU with them,
// then latches the ALU result and an error flag for display.
module alu_operand_sequencer #(
  // Synchroniser depth for the two buttons; must be 2 or more.
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  input  logic       load,
  input  logic       clear,
  input  logic [5:0] alu_result,
  output logic [2:0] alu_ctrl,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [2:0] phase,
  output logic [5:0] result,
  output logic       result_valid,
  output logic       err
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] loadSync_q;
  logic [SYNC_STAGES-1:0] clearSync_q;
  logic                   loadHist_q;
  logic [2:0]             aluA_q;
  logic [2:0]             aluB_q;
  logic [2:0]             aluCtrl_q;
  logic [5:0]             result_q;
  logic                   resultValid_q;
  logic                   err_q;

  logic                   loadLevel;
  logic                   clearLevel;
  logic                   ldPulse;
  logic                   execErr_d;
  logic [5:0]             execResult_d;

  // Button synchronisers and load edge history. Everything resets high, so a
  // button that is still held when reset is released does not count as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadSync_q  <= '1;
      clearSync_q <= '1;
      loadHist_q  <= 1'b1;
    end else begin
      loadSync_q  <= {loadSync_q[SYNC_STAGES-2:0], load};
      clearSync_q <= {clearSync_q[SYNC_STAGES-2:0], clear};
      loadHist_q  <= loadSync_q[SYNC_STAGES-1];
    end
  end

  assign loadLevel  = loadSync_q[SYNC_STAGES-1];
  assign clearLevel = clearSync_q[SYNC_STAGES-1];
  assign ldPulse    = loadLevel & ~loadHist_q;

  // Undefined opcodes, and divide or modulo by zero, are reported as errors
  // with a zero result. Otherwise the ALU's 6-bit answer is passed through
  // unchanged.
  assign execErr_d    = (aluCtrl_q > 3'd4) |
                        (((aluCtrl_q == 3'd3) | (aluCtrl_q == 3'd4)) & (aluB_q == 3'd0));
  assign execResult_d = execErr_d ? 6'd0 : alu_result;

  // Entry sequencer: A, B, opcode, one execute cycle, then hold the result.
  // Clear overrides any load press, in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_A;
      aluA_q        <= 3'd0;
      aluB_q        <= 3'd0;
      aluCtrl_q     <= 3'd0;
      result_q      <= 6'd0;
      resultValid_q <= 1'b0;
      err_q         <= 1'b0;
    end else if (clearLevel) begin
      state_q       <= S_A;
      aluA_q        <= 3'd0;
      aluB_q        <= 3'd0;
      aluCtrl_q     <= 3'd0;
      result_q      <= 6'd0;
      resultValid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (ldPulse) begin
            aluA_q  <= din;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (ldPulse) begin
            aluB_q  <= din;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          if (ldPulse) begin
            aluCtrl_q <= din;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q      <= execResult_d;
          err_q         <= execErr_d;
          resultValid_q <= 1'b1;
          state_q       <= S_SHOW;
        end
        S_SHOW: begin
          if (ldPulse) begin
            resultValid_q <= 1'b0;
            err_q         <= 1'b0;
            state_q       <= S_A;
          end
        end
        default: begin
          state_q <= S_A;
        end
      endcase
    end
  end

  assign alu_a        = aluA_q;
  assign alu_b        = aluB_q;
  assign alu_ctrl     = aluCtrl_q;
  assign phase        = state_q;
  assign result       = result_q;
  assign result_valid = resultValid_q;
  assign err          = err_q;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Front-end that drives the 3-bit ALU's ctrl/A/B inputs from a single shared 3-bit switch bus and one load button.
- Operands A and B, then the opcode, are entered one at a time.
- After the opcode is entered, the block registers the ALU result together with an error flag and holds them for display.
- Sits between the board I/O pins and the ALU instance, and consumes the ALU's 6-bit result.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on load and clear; legal values are 2 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- din  input  3  shared data switches; carries A, then B, then the opcode
- load  input  1  load button, asynchronous to clk; only its rising edge is used
- clear  input  1  abort button, asynchronous to clk; level-sensitive after synchronisation
- alu_result  input  6  result returned by the ALU for the currently driven ctrl/A/B
- alu_ctrl  output  3  opcode driven to the ALU
- alu_a  output  3  operand A driven to the ALU
- alu_b  output  3  operand B driven to the ALU
- phase  output  3  current FSM state code, for status LEDs
- result  output  6  latched result
- result_valid  output  1  high while a latched result is being shown
- err  output  1  latched error flag for the shown result

Behaviour:
- Reset values (asynchronous on rst=1):
  - alu_ctrl=0, alu_a=0, alu_b=0, result=0, result_valid=0, err=0.
  - State is S_A.
  - All synchroniser flops and the load edge-history flop reset to 1, so a button held through reset release produces no press.
- Input conditioning:
  - load and clear each pass through SYNC_STAGES flops.
  - ld_p = load_sync & ~load_hist, a one-cycle pulse.
  - Capture occurs on the (SYNC_STAGES+1)th rising clk edge after load first goes high.
  - Holding load high produces exactly one pulse.
- FSM states (phase codes):
  - S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - S_A: on ld_p, alu_a<=din and go to S_B.
  - S_B: on ld_p, alu_b<=din and go to S_OP.
  - S_OP: on ld_p, alu_ctrl<=din and go to S_EXEC.
  - S_EXEC: lasts exactly one cycle and ignores ld_p.
    - err_n = (alu_ctrl>4) | ((alu_ctrl==3 | alu_ctrl==4) & alu_b==0).
    - result <= err_n ? 0 : alu_result.
    - err <= err_n; result_valid <= 1; go to S_SHOW.
  - S_SHOW: result, result_valid and err are held.
    - On ld_p: result_valid<=0, err<=0, go to S_A. result keeps its value until overwritten.
    - alu_a/alu_b/alu_ctrl are held, so the next entry overwrites them one at a time.
- alu_ctrl/A/B are registered outputs and change only on capture edges; the ALU path is combinational, so alu_result is settled by S_EXEC.
- Width rules:
  - alu_result is taken as the full 6 bits; no truncation or extension in this block.
  - The ALU owns its own arithmetic; this block only masks divide-by-zero and undefined opcodes to 0.
- Clear:
  - Synchronised clear high has priority over ld_p in every state, including S_EXEC.
  - Next state is S_A; alu_a, alu_b, alu_ctrl, result, result_valid and err all go to 0.
  - Clear takes effect every cycle it is high; ld_p arriving while clear is high is discarded.
- Reset mid-operation: any state goes immediately to reset values; no partial capture survives.
- No other state transitions exist; din is ignored except on a capture cycle.

Test Plan:
1. Reset with load held high, release rst, keep load high for 20 cycles -> phase stays 0, alu_a=0, no capture.
2. Presses with din=3, then 2, then opcode 0 -> alu_a=3, alu_b=2, alu_ctrl=0. Exactly one cycle later: result=5, result_valid=1, err=0, phase=4. Each capture lands SYNC_STAGES+1 edges after its press.
3. A=7, B=7, opcode 2 (ALU model returns 49) -> result=6'd49, err=0. Next press -> result_valid=0, phase=0, result still 49.
4. A=5, B=0, opcode 3, and separately opcode 4 -> result=0, err=1, result_valid=1. Then opcode 6 with B=1 -> result=0, err=1.
5. Enter A=4, B=1, assert clear while in S_OP, with load pressed in the same cycle -> phase=0, alu_a=0, alu_b=0, no opcode captured. A fresh full entry then works normally.
6. Assert rst asynchronously between clock edges while in S_SHOW with result=49 -> all outputs 0 immediately, before the next clk edge. A single 1-cycle load glitch shorter than one clk period, aligned to miss the sampling edge -> no capture.
